// File: rtl/run_sequencer.sv
// Command-driven initiator for the INIT/RUNNING run-control FSM.
// Issues start/stop strobes, shadows the FSM state and reports completion.
module run_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_len,
  input  logic             abort,
  output logic             start,
  output logic             stop,
  output logic             running,
  output logic [CNT_W-1:0] remaining,
  output logic             done,
  output logic             aborted
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t state, nxt;

  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] rem_d;
  logic             hit_q, hit_d;
  logic             accept;
  logic             rdy_d, start_d, stop_d;
  logic             run_d, done_d, abd_d;

  assign accept = cmd_valid & cmd_ready;

  // Outputs are registered from the next-state decode,
  // so each one lines up with the state it describes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      len_q     <= '0;
      hit_q     <= 1'b0;
      cmd_ready <= 1'b0;
      start     <= 1'b0;
      stop      <= 1'b0;
      running   <= 1'b0;
      remaining <= '0;
      done      <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      state     <= nxt;
      hit_q     <= hit_d;
      cmd_ready <= rdy_d;
      start     <= start_d;
      stop      <= stop_d;
      running   <= run_d;
      remaining <= rem_d;
      done      <= done_d;
      aborted   <= abd_d;
      if (accept)
        len_q <= cmd_len;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (accept && cmd_len != '0)
          nxt = START;
      end
      START: begin
        nxt = abort ? STOP : RUN;
      end
      RUN: begin
        if (abort || remaining == CNT_W'(1))
          nxt = STOP;
      end
      STOP: begin
        nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    rdy_d   = (nxt == IDLE);
    start_d = (nxt == START);
    stop_d  = (nxt == STOP);
    run_d   = (nxt == RUN) || (nxt == STOP);
    rem_d   = '0;
    if (nxt == RUN)
      rem_d = (state == START) ? len_q
                               : remaining - CNT_W'(1);
    done_d = (state == STOP) ||
             (state == IDLE && accept && cmd_len == '0);
    // Remember whether this run was cut short.
    hit_d = hit_q;
    if (state == IDLE)
      hit_d = 1'b0;
    else if ((state == START || state == RUN) && abort)
      hit_d = 1'b1;
    abd_d = (state == STOP) && hit_q;
  end

endmodule

// File: tb/tb_run_sequencer.sv
// Bench for run_sequencer: directed scenarios plus random commands
// checked against a per-command timeline model.
module tb_run_sequencer;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [W-1:0] cmd_len;
  logic         abort;
  logic         start;
  logic         stop;
  logic         running;
  logic [W-1:0] remaining;
  logic         done;
  logic         aborted;

  int vectors = 0;
  int miscompares = 0;

  // Timeline model state
  int cyc = 0;
  int rdy_from = 1;
  bit have = 0;
  int t0 = 0;
  int len_m = 0;
  int e_stop = 0;
  bit abd_m = 0;
  int n_acc = 0;

  // Downstream INIT/RUNNING FSM model
  logic fsm_run;

  run_sequencer #(.CNT_W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_len   (cmd_len),
    .abort     (abort),
    .start     (start),
    .stop      (stop),
    .running   (running),
    .remaining (remaining),
    .done      (done),
    .aborted   (aborted)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst)
      fsm_run <= 1'b0;
    else if (start)
      fsm_run <= 1'b1;
    else if (stop)
      fsm_run <= 1'b0;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s cyc=%0d: observed %0h expected %0h",
             tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, 32'(cmd_ready), 0);
    chk({tag, "_start"}, 32'(start), 0);
    chk({tag, "_stop"}, 32'(stop), 0);
    chk({tag, "_running"}, 32'(running), 0);
    chk({tag, "_remaining"}, 32'(remaining), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_aborted"}, 32'(aborted), 0);
  endtask

  // Called at a negedge: check cycle cyc, drive its inputs,
  // advance the model, move to the next negedge.
  task automatic step(input logic v,
                      input logic [W-1:0] len,
                      input logic ab);
    int  c;
    bit  busy;
    int  dc;
    bit  x_rdy, x_st, x_sp, x_run, x_done, x_abd;
    int  x_rem;
    c = cyc;
    busy = have && len_m > 0 && c <= e_stop;
    x_rdy = 0; x_st = 0; x_sp = 0; x_run = 0;
    x_done = 0; x_abd = 0; x_rem = 0;
    if (busy) begin
      x_st  = (c == t0 + 1);
      x_sp  = (c == e_stop);
      x_run = (c >= t0 + 2);
      if (c >= t0 + 2 && c < e_stop)
        x_rem = len_m - (c - t0 - 2);
    end else begin
      x_rdy  = (c >= rdy_from);
      dc     = (len_m > 0) ? e_stop + 1 : t0 + 1;
      x_done = have && (c == dc);
      x_abd  = x_done && abd_m;
    end
    chk("cmd_ready", 32'(cmd_ready), 32'(x_rdy));
    chk("start", 32'(start), 32'(x_st));
    chk("stop", 32'(stop), 32'(x_sp));
    chk("running", 32'(running), 32'(x_run));
    chk("remaining", 32'(remaining), 32'(x_rem));
    chk("done", 32'(done), 32'(x_done));
    chk("aborted", 32'(aborted), 32'(x_abd));
    chk("fsm_shadow", 32'(running), 32'(fsm_run));
    chk("start_stop_excl", 32'(start & stop), 0);
    cmd_valid = v;
    cmd_len   = len;
    abort     = ab;
    if (have && len_m > 0 && c >= t0 + 1 && c < e_stop && ab) begin
      e_stop = c + 1;
      abd_m  = 1;
    end
    if (x_rdy && v) begin
      have   = 1;
      t0     = c;
      len_m  = int'(len);
      e_stop = c + 2 + int'(len);
      abd_m  = 0;
      n_acc++;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, W'($urandom), 1'b0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    chk_zero(tag);
    @(negedge clk);
    chk_zero({tag, "_held"});
    rst = 1'b0;
    cyc++;
    have = 0;
    rdy_from = cyc + 1;
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_len = '0;
    abort = 1'b0;
    @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    cyc = 0;
    rdy_from = 1;

    // 1: len 3
    step(1'b0, 16'd0, 1'b0);
    step(1'b1, 16'd3, 1'b0);
    idle(7);

    // 2: len 0
    step(1'b1, 16'd0, 1'b0);
    idle(3);

    // 3: len 10, abort at T0+4
    step(1'b1, 16'd10, 1'b0);
    idle(3);
    step(1'b0, 16'd0, 1'b1);
    idle(4);

    // 4: abort held from accept
    step(1'b1, 16'd5, 1'b1);
    for (int i = 0; i < 4; i++)
      step(1'b0, 16'd0, 1'b1);
    idle(3);

    // 5: back-to-back, valid held
    n_acc = 0;
    for (int i = 0; i < 20 && n_acc < 2; i++)
      step(1'b1, (n_acc == 0) ? 16'd2 : 16'd1, 1'b0);
    idle(6);

    // abort in the last RUN cycle
    step(1'b1, 16'd4, 1'b0);
    idle(4);
    step(1'b0, 16'd0, 1'b1);
    idle(3);

    // full-width length, abort shortly after loading
    step(1'b1, 16'hFFFF, 1'b0);
    idle(6);
    step(1'b0, 16'd0, 1'b1);
    idle(3);

    // 6: reset mid-RUN
    step(1'b1, 16'd100, 1'b0);
    idle(20);
    do_reset("midrun_reset");
    step(1'b1, 16'd1, 1'b0);
    step(1'b1, 16'd1, 1'b0);
    idle(6);

    // random commands with occasional aborts
    for (int i = 0; i < 400; i++) begin
      logic v, ab;
      logic [W-1:0] l;
      v  = ($urandom_range(0, 2) != 0);
      l  = ($urandom_range(0, 3) == 0) ? 16'd0
                                       : W'($urandom_range(1, 12));
      ab = ($urandom_range(0, 11) == 0);
      step(v, l, ab);
    end
    idle(20);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
